memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: calculated result, store data and the 12-bit control word.
- Runs load/store transactions on a req/gnt/rvalid data-memory port, formats load data and drives the MEM/WB register.
- Provides the MEM forwarding value and a pipeline stall to the hazard logic.

Parameters:
- size, 32, datapath and address width.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- valid_i  input  1  EX/MEM holds a live instruction
- calculated_result_i  input  size  ALU result or memory address
- store_data_i  input  size  unaligned store data, low-justified
- control_signal_i  input  12  [11:7] rd, [6] reg_write, [5] reserved/ignored, [4] mem_write, [3] mem_read, [2:0] funct3
- dmem_req_o  output  1  memory request
- dmem_we_o  output  1  1 = store
- dmem_addr_o  output  size  word-aligned address ({addr[size-1:2],2'b00})
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  size  lane-shifted store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  response valid (load data or store ack)
- dmem_rdata_i  input  size  load word
- stall_o  output  1  freeze IF..EX and the EX/MEM register
- mem_fwd_data_o  output  size  forwarding value, equal to calculated_result_i (combinational)
- wb_data_o  output  size  MEM/WB write-back data
- rd_addr_o  output  5  MEM/WB destination register
- reg_write_o  output  1  MEM/WB write enable
- misaligned_o  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- State machine: IDLE, WAIT_GNT, WAIT_RSP.
- Memory op means valid_i && (mem_read || mem_write). If both bits are set, the op is treated as a load.
- IDLE, no memory op:
  - next edge: wb_data_o <= calculated_result_i, rd_addr_o <= rd, reg_write_o <= reg_write && valid_i.
  - 1-cycle latency, stall_o = 0.
- IDLE, memory op:
  - dmem_req_o = 1 combinationally in the same cycle.
  - gnt=1: go to WAIT_RSP. gnt=0: go to WAIT_GNT.
  - stall_o = 1.
- WAIT_GNT:
  - dmem_req_o held at 1; addr, we, be and wdata held stable; stall_o = 1.
  - On gnt, go to WAIT_RSP.
- WAIT_RSP:
  - dmem_req_o = 0.
  - While rvalid = 0: stall_o = 1.
  - In the rvalid cycle: stall_o = 0, MEM/WB is loaded, return to IDLE.
  - Load: wb_data_o = formatted rdata, reg_write_o = reg_write.
  - Store: reg_write_o = 0.
- Minimum memory-op latency: 2 cycles (gnt in the request cycle, rvalid the next cycle).
- Every stalled cycle writes a bubble into MEM/WB (reg_write_o = 0); wb_data_o and rd_addr_o hold.
- Upstream keeps all inputs stable while stall_o = 1.
- Store formatting:
  - SB (funct3 000): be = 0001 << addr[1:0], byte replicated on all 4 lanes.
  - SH (001): be = addr[1] ? 1100 : 0011, half replicated on both halves.
  - SW (010): be = 1111.
- Load formatting:
  - LB (000) / LBU (100): select byte at addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH (001) / LHU (101): select half at addr[1]; LH sign-extends, LHU zero-extends.
  - LW (010): full word.
  - Any other funct3: full word.
- For loads, dmem_be_o = 1111.
- Without the trap feature, misalignment is ignored: LH/SH use addr[1] only, LW/SW ignore addr[1:0].
- A rvalid that arrives in IDLE or WAIT_GNT is ignored.
- Reset (sync, high):
  - state <= IDLE.
  - wb_data_o, rd_addr_o, reg_write_o, misaligned_o <= 0.
  - An outstanding transaction is abandoned and dmem_req_o drops in the next cycle.
  - Any late rvalid after reset is ignored.
- When not requesting, all dmem_* outputs are 0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - A misaligned memory op issues no request and stays in IDLE with stall_o = 0.
  - MEM/WB is loaded with reg_write_o = 0.
  - misaligned_o is a registered 1-cycle pulse.
- Undefined:
  - misaligned_o is tied to 0.
  - Accesses proceed with the address alignment described above.

Test Plan:
- ADD result 0x0000_1234, rd = 5, reg_write = 1, no mem op -> next cycle: wb_data_o = 0x1234, rd_addr_o = 5, reg_write_o = 1, stall_o never high.
- LB addr 0x103, gnt same cycle, rvalid next cycle with rdata 0x80AA_BBCC -> 2 stall-low-at-end cycles, wb_data_o = 0xFFFF_FF80; LBU same case -> 0x0000_0080.
- SH addr 0x202, store_data 0x0000_BEEF, gnt delayed 3 cycles -> req, addr 0x200, be 1100, wdata 0xBEEF_BEEF held for 4 cycles; stall_o = 1 until the rvalid cycle; reg_write_o = 0 throughout.
- LW addr 0x40, gnt then rvalid delayed 5 cycles -> stall_o = 1 for every cycle before rvalid, bubbles in MEM/WB; on rvalid, wb_data_o = rdata and reg_write_o = 1.
- Reset asserted in WAIT_RSP, then rvalid arrives -> outputs zero, state IDLE, rvalid ignored, no write-back.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x41 -> dmem_req_o stays 0, misaligned_o pulses 1 cycle, reg_write_o = 0.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory port bundle between the memory stage (master) and the data
// memory (slave): req/gnt handshake with a separate rvalid response phase.
interface memory_stage_if #(
   parameter int size = 32
);
   logic            req;
   logic            we;
   logic [size-1:0] addr;
   logic [3:0]      be;
   logic [size-1:0] wdata;
   logic            gnt;
   logic            rvalid;
   logic [size-1:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Runs loads/stores on a
// req/gnt/rvalid memory port, formats load data and drives MEM/WB.
// Byte-lane logic assumes a 32-bit datapath (size = 32).
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses issue no request and pulse misaligned_o for one cycle;
// when undefined, misaligned_o stays 0 and low address bits are ignored.
module memory_stage #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [size-1:0] calculated_result_i,
   input  logic [size-1:0] store_data_i,
   input  logic [11:0]     control_signal_i,
   memory_stage_if.master  dmem,
   output logic            stall_o,
   output logic [size-1:0] mem_fwd_data_o,
   output logic [size-1:0] wb_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            reg_write_o,
   output logic            misaligned_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_GNT = 2'd1;
   localparam logic [1:0] WAIT_RSP = 2'd2;

   // Byte enables for a store, derived from width and address offset.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      case (f3)
         3'b000:  be = 4'b0001 << a;
         3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across lanes so the enabled lanes carry the value.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3)
         3'b000:  w = {4{d[7:0]}};
         3'b001:  w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Extract and extend the addressed byte/half of a load word.
   function automatic logic [31:0] format_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h000000, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0000, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic m;
      case (f3)
         3'b001, 3'b101: m = a[0];
         3'b010:         m = (a != 2'b00);
         default:        m = 1'b0;
      endcase
      return m;
   endfunction

   logic [1:0]      state_q, state_d;
   logic [size-1:0] wb_data_q, wb_data_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic            reg_write_q, reg_write_d;
   logic            misaligned_q, misaligned_d;

   logic [4:0] rd_s;
   logic       reg_write_s, mem_write_s, mem_read_s;
   logic [2:0] funct3_s;
   logic       mem_op_s, is_load_s, misaligned_s;
   logic       req_s, stall_s, issue_s;
   logic       unused_ctrl_s;

   assign rd_s          = control_signal_i[11:7];
   assign reg_write_s   = control_signal_i[6];
   assign unused_ctrl_s = control_signal_i[5];
   assign mem_write_s   = control_signal_i[4];
   assign mem_read_s    = control_signal_i[3];
   assign funct3_s      = control_signal_i[2:0];

   assign mem_op_s  = valid_i && (mem_read_s || mem_write_s);
   // A load/store encoding with both bits set behaves as a load.
   assign is_load_s = mem_read_s;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned_s = mem_op_s && is_misaligned(funct3_s, calculated_result_i[1:0]);
`else
   assign misaligned_s = 1'b0;
`endif

   // FSM next state, handshake/stall control and MEM/WB next values.
   always_comb begin
      state_d      = state_q;
      wb_data_d    = wb_data_q;
      rd_addr_d    = rd_addr_q;
      reg_write_d  = 1'b0;
      misaligned_d = 1'b0;
      req_s        = 1'b0;
      stall_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op_s && !misaligned_s) begin
               req_s   = 1'b1;
               stall_s = 1'b1;
               state_d = dmem.gnt ? WAIT_RSP : WAIT_GNT;
            end else begin
               wb_data_d    = calculated_result_i;
               rd_addr_d    = rd_s;
               reg_write_d  = reg_write_s && valid_i && !mem_op_s;
               misaligned_d = misaligned_s;
            end
         end
         WAIT_GNT: begin
            req_s   = 1'b1;
            stall_s = 1'b1;
            if (dmem.gnt) begin
               state_d = WAIT_RSP;
            end else begin
               state_d = WAIT_GNT;
            end
         end
         WAIT_RSP: begin
            if (dmem.rvalid) begin
               state_d   = IDLE;
               rd_addr_d = rd_s;
               if (is_load_s) begin
                  wb_data_d   = format_load(dmem.rdata, funct3_s, calculated_result_i[1:0]);
                  reg_write_d = reg_write_s && valid_i;
               end else begin
                  wb_data_d   = calculated_result_i;
                  reg_write_d = 1'b0;
               end
            end else begin
               stall_s = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory port drive: everything zero unless a request is being presented.
   always_comb begin
      issue_s = req_s && !reset;
      if (issue_s) begin
         dmem.req   = 1'b1;
         dmem.we    = !is_load_s;
         dmem.addr  = {calculated_result_i[size-1:2], 2'b00};
         dmem.be    = is_load_s ? 4'b1111 : store_be(funct3_s, calculated_result_i[1:0]);
         dmem.wdata = is_load_s ? '0 : store_wdata(funct3_s, store_data_i);
      end else begin
         dmem.req   = 1'b0;
         dmem.we    = 1'b0;
         dmem.addr  = '0;
         dmem.be    = 4'b0000;
         dmem.wdata = '0;
      end
   end

   // State and MEM/WB registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wb_data_q    <= '0;
         rd_addr_q    <= 5'd0;
         reg_write_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wb_data_q    <= wb_data_d;
         rd_addr_q    <= rd_addr_d;
         reg_write_q  <= reg_write_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign stall_o        = stall_s;
   assign mem_fwd_data_o = calculated_result_i;
   assign wb_data_o      = wb_data_q;
   assign rd_addr_o      = rd_addr_q;
   assign reg_write_o    = reg_write_q;
   assign misaligned_o   = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vectors, scoreboard queue of
// expected MEM/WB results popped by an independent monitor.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] calc_i;
   logic [31:0] sdata_i;
   logic [11:0] ctrl_i;
   logic        stall_o;
   logic [31:0] fwd_o;
   logic [31:0] wb_o;
   logic [4:0]  rd_o;
   logic        rw_o;
   logic        mis_o;

   memory_stage_if #(.size(32)) dmem_if ();

   memory_stage #(.size(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .valid_i             (valid_i),
      .calculated_result_i (calc_i),
      .store_data_i        (sdata_i),
      .control_signal_i    (ctrl_i),
      .dmem                (dmem_if.master),
      .stall_o             (stall_o),
      .mem_fwd_data_o      (fwd_o),
      .wb_data_o           (wb_o),
      .rd_addr_o           (rd_o),
      .reg_write_o         (rw_o),
      .misaligned_o        (mis_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wb;
      logic [4:0]  rd;
      logic        rw;
      logic        mis;
      logic        chk_wb;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic retire_pend = 1'b0;
   logic bubble_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] mk_ctrl(input logic [4:0] rd, input logic rw, input logic mw,
                                           input logic mr, input logic [2:0] f3);
      return {rd, rw, 1'b0, mw, mr, f3};
   endfunction

   // Monitor: a cycle with valid_i and no stall retires into MEM/WB; check it
   // one cycle later against the scoreboard. Stalled cycles must leave bubbles.
   always @(negedge clk) begin
      if (retire_pend) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_retire", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("mon_reg_write", {31'd0, rw_o}, {31'd0, e.rw});
            chk("mon_rd_addr", {27'd0, rd_o}, {27'd0, e.rd});
            chk("mon_misaligned", {31'd0, mis_o}, {31'd0, e.mis});
            if (e.chk_wb) chk("mon_wb_data", wb_o, e.wb);
         end
      end
      if (bubble_pend) chk("mon_bubble", {31'd0, rw_o}, 32'd0);
      retire_pend = valid_i && !stall_o && !reset;
      bubble_pend = stall_o && !reset;
   end

   task automatic idle_inputs();
      valid_i        = 1'b0;
      calc_i         = 32'd0;
      sdata_i        = 32'd0;
      ctrl_i         = 12'd0;
      dmem_if.gnt    = 1'b0;
      dmem_if.rvalid = 1'b0;
      dmem_if.rdata  = 32'd0;
   endtask

   // One memory op: gnt after gdly request cycles, rvalid rdly cycles later.
   task automatic mem_op(input logic [4:0] rd, input logic mw, input logic mr,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                         input int gdly, input int rdly, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb);
      exp_t e;
      @(posedge clk); #1;
      valid_i     = 1'b1;
      calc_i      = addr;
      sdata_i     = sdata;
      ctrl_i      = mk_ctrl(rd, 1'b1, mw, mr, f3);
      dmem_if.gnt = (gdly == 0);
      for (int i = 0; i <= gdly; i++) begin
         @(negedge clk);
         chk("req_high", {31'd0, dmem_if.req}, 32'd1);
         chk("req_we", {31'd0, dmem_if.we}, {31'd0, !mr});
         chk("req_addr", dmem_if.addr, {addr[31:2], 2'b00});
         chk("req_be", {28'd0, dmem_if.be}, {28'd0, exp_be});
         if (!mr) chk("req_wdata", dmem_if.wdata, exp_wdata);
         chk("stall_req", {31'd0, stall_o}, 32'd1);
         @(posedge clk); #1;
         dmem_if.gnt = (i + 1 == gdly);
      end
      for (int j = 0; j < rdly; j++) begin
         @(negedge clk);
         chk("stall_rsp_wait", {31'd0, stall_o}, 32'd1);
         chk("req_low_rsp", {31'd0, dmem_if.req}, 32'd0);
         @(posedge clk); #1;
      end
      dmem_if.rvalid = 1'b1;
      dmem_if.rdata  = rdata;
      e.wb = exp_wb; e.rd = rd; e.rw = mr; e.mis = 1'b0; e.chk_wb = mr;
      sb_q.push_back(e);
      @(negedge clk);
      chk("stall_rvalid", {31'd0, stall_o}, 32'd0);
      chk("req_low_rvalid", {31'd0, dmem_if.req}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      exp_t e;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_wb", wb_o, 32'd0);
      chk("rst_rd", {27'd0, rd_o}, 32'd0);
      chk("rst_rw", {31'd0, rw_o}, 32'd0);
      chk("rst_mis", {31'd0, mis_o}, 32'd0);
      chk("rst_req", {31'd0, dmem_if.req}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);

      // ALU op, no memory access
      @(posedge clk); #1;
      valid_i = 1'b1;
      calc_i  = 32'h0000_1234;
      ctrl_i  = mk_ctrl(5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      e.wb = 32'h0000_1234; e.rd = 5'd5; e.rw = 1'b1; e.mis = 1'b0; e.chk_wb = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      chk("add_stall", {31'd0, stall_o}, 32'd0);
      chk("add_req", {31'd0, dmem_if.req}, 32'd0);
      chk("add_fwd", fwd_o, 32'h0000_1234);
      @(posedge clk); #1;
      idle_inputs();

      //      rd    mw    mr    f3      addr          sdata         g  r  rdata         be       wdata         wb
      mem_op(5'd7,  1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'd0,         0, 0, 32'h80AA_BBCC, 4'b1111, 32'd0,         32'hFFFF_FF80);
      mem_op(5'd8,  1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'd0,         0, 0, 32'h80AA_BBCC, 4'b1111, 32'd0,         32'h0000_0080);
      mem_op(5'd9,  1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 3, 0, 32'd0,         4'b1100, 32'hBEEF_BEEF, 32'd0);
      mem_op(5'd10, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'd0,         0, 5, 32'hDEAD_BEEF, 4'b1111, 32'd0,         32'hDEAD_BEEF);
      mem_op(5'd13, 1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0001_2345, 1, 1, 32'd0,         4'b0010, 32'h4545_4545, 32'd0);
      mem_op(5'd14, 1'b1, 1'b0, 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 0, 2, 32'd0,         4'b1111, 32'hCAFE_F00D, 32'd0);
      mem_op(5'd15, 1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'd0,         2, 0, 32'h8001_7FFF, 4'b1111, 32'd0,         32'hFFFF_8001);
      mem_op(5'd16, 1'b0, 1'b1, 3'b101, 32'h0000_0302, 32'd0,         0, 1, 32'h8001_7FFF, 4'b1111, 32'd0,         32'h0000_8001);
      mem_op(5'd17, 1'b1, 1'b1, 3'b010, 32'h0000_0044, 32'h1111_1111, 0, 0, 32'h1234_5678, 4'b1111, 32'd0,         32'h1234_5678);

      // Reset while waiting for the response; the late rvalid must be ignored
      @(posedge clk); #1;
      valid_i     = 1'b1;
      calc_i      = 32'h0000_0080;
      ctrl_i      = mk_ctrl(5'd11, 1'b1, 1'b0, 1'b1, 3'b010);
      dmem_if.gnt = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      dmem_if.gnt = 1'b0;
      @(negedge clk);
      chk("rsp_wait_stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
      dmem_if.rvalid = 1'b1;
      dmem_if.rdata  = 32'h5555_AAAA;
      @(negedge clk);
      chk("mrst_wb", wb_o, 32'd0);
      chk("mrst_rd", {27'd0, rd_o}, 32'd0);
      chk("mrst_rw", {31'd0, rw_o}, 32'd0);
      chk("mrst_req", {31'd0, dmem_if.req}, 32'd0);
      chk("mrst_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("late_rvalid_rw", {31'd0, rw_o}, 32'd0);
      chk("late_rvalid_wb", wb_o, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned LW: no request, one-cycle misaligned pulse, no write-back
      @(posedge clk); #1;
      valid_i = 1'b1;
      calc_i  = 32'h0000_0041;
      ctrl_i  = mk_ctrl(5'd12, 1'b1, 1'b0, 1'b1, 3'b010);
      e.wb = 32'd0; e.rd = 5'd12; e.rw = 1'b0; e.mis = 1'b1; e.chk_wb = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      chk("mis_req", {31'd0, dmem_if.req}, 32'd0);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("mis_pulse", {31'd0, mis_o}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_pulse_end", {31'd0, mis_o}, 32'd0);
`else
      // Without the trap a misaligned LW proceeds with the word-aligned address
      mem_op(5'd12, 1'b0, 1'b1, 3'b010, 32'h0000_0041, 32'd0, 0, 0, 32'h1122_3344, 4'b1111, 32'd0, 32'h1122_3344);
      @(negedge clk);
      chk("no_trap_mis", {31'd0, mis_o}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
